// File: rtl/cfa_pkg.sv
// Shared definitions for the CFA demosaic front end.
//   PIX_W    : pixel width, common to diag_window_gen and pre_equ_24_27
//   clog2    : counter/address width helper (never returns less than 1)
//   corner_t : one plane's set of four diagonal neighbours
package cfa_pkg;

    localparam int unsigned PIX_W = 12;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        v      = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return (result == 0) ? 1 : result;
    endfunction

    typedef struct packed {
        logic [PIX_W-1:0] m1_m1;
        logic [PIX_W-1:0] m1_p1;
        logic [PIX_W-1:0] p1_m1;
        logic [PIX_W-1:0] p1_p1;
    } corner_t;

endpackage

// File: rtl/cfa_line_buf.sv
// Single-port line buffer with read-before-write behaviour.
//   clk_i   : rising-edge clock
//   we_i    : write strobe; the entry at addr_i is replaced at the clock edge
//   addr_i  : column address
//   wdata_i : value written when we_i is set
//   rdata_o : combinational read of the entry at addr_i (old contents on a write cycle)
// Contents are not reset.
module cfa_line_buf
    import cfa_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 12,
    localparam int unsigned AW = clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata_o = mem[addr_i];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/diag_window_gen.sv
// Diagonal-neighbour window generator feeding pre_equ_24_27.
// Takes co-registered G and R/B rasters (one pixel pair per cycle) and, for every interior
// centre, emits the four diagonal corners of both planes plus the centre coordinates.
//   clk, rst (async, active low)
//   in_valid/in_ready/in_sof, in_g, in_rb      : input stream, sof forces the pixel to (0,0)
//   out_valid/out_ready                        : output handshake, output held until taken
//   G_*/RB_* corners, ctr_x, ctr_y             : window for centre (ctr_x, ctr_y)
//   frame_done                                 : pulse after the last pixel of a frame
module diag_window_gen
    import cfa_pkg::*;
#(
    parameter int unsigned IMG_W = 64,
    parameter int unsigned IMG_H = 64,
    localparam int unsigned X_W = clog2(IMG_W),
    localparam int unsigned Y_W = clog2(IMG_H)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_g,
    input  logic [PIX_W-1:0] in_rb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] G_m1_m1,
    output logic [PIX_W-1:0] G_m1_p1,
    output logic [PIX_W-1:0] G_p1_m1,
    output logic [PIX_W-1:0] G_p1_p1,
    output logic [PIX_W-1:0] RB_m1_m1,
    output logic [PIX_W-1:0] RB_m1_p1,
    output logic [PIX_W-1:0] RB_p1_m1,
    output logic [PIX_W-1:0] RB_p1_p1,
    output logic [X_W-1:0]   ctr_x,
    output logic [Y_W-1:0]   ctr_y,
    output logic             frame_done
);

    logic             accept;
    logic [X_W-1:0]   x_q, x_d, cur_x;
    logic [Y_W-1:0]   y_q, y_d, cur_y;
    logic             last_col, last_row, win;

    // Line-buffer read ports: rd1 = row y-1, rd2 = row y-2, both at column cur_x.
    logic [PIX_W-1:0] g_rd1, g_rd2, rb_rd1, rb_rd2;

    // Columns x-1 (index 0) and x-2 (index 1); column x is the live read / input pixel,
    // which together form the three-deep column window without an extra cycle of latency.
    logic [1:0][PIX_W-1:0] g_top_q, g_bot_q, rb_top_q, rb_bot_q;

    corner_t          g_win, rb_win, g_q, rb_q;
    logic             out_valid_q, out_valid_d;
    logic [X_W-1:0]   ctr_x_q;
    logic [Y_W-1:0]   ctr_y_q;
    logic             frame_done_q;

    assign in_ready = out_ready | ~out_valid_q;
    assign accept   = in_valid & in_ready;

    // sof overrides whatever the counters hold, so a new frame can start at any point.
    assign cur_x    = in_sof ? '0 : x_q;
    assign cur_y    = in_sof ? '0 : y_q;
    assign last_col = (cur_x == X_W'(IMG_W - 1));
    assign last_row = (cur_y == Y_W'(IMG_H - 1));
    // y >= 2 also guarantees that stale line-buffer rows from an abandoned frame are never used.
    assign win      = (cur_x >= X_W'(2)) && (cur_y >= Y_W'(2));

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (accept) begin
            if (last_col) begin
                x_d = '0;
                y_d = last_row ? '0 : cur_y + Y_W'(1);
            end else begin
                x_d = cur_x + X_W'(1);
                y_d = cur_y;
            end
        end
    end

    // Row y-1 buffer takes the new pixel, its old contents cascade into the row y-2 buffer.
    cfa_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_g_lb1 (
        .clk_i   (clk),
        .we_i    (accept),
        .addr_i  (cur_x),
        .wdata_i (in_g),
        .rdata_o (g_rd1)
    );

    cfa_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_g_lb2 (
        .clk_i   (clk),
        .we_i    (accept),
        .addr_i  (cur_x),
        .wdata_i (g_rd1),
        .rdata_o (g_rd2)
    );

    cfa_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_rb_lb1 (
        .clk_i   (clk),
        .we_i    (accept),
        .addr_i  (cur_x),
        .wdata_i (in_rb),
        .rdata_o (rb_rd1)
    );

    cfa_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_rb_lb2 (
        .clk_i   (clk),
        .we_i    (accept),
        .addr_i  (cur_x),
        .wdata_i (rb_rd1),
        .rdata_o (rb_rd2)
    );

    // Centre is (x-1, y-1): top corners come from row y-2, bottom corners from row y.
    always_comb begin
        g_win.m1_m1  = g_top_q[1];
        g_win.m1_p1  = g_rd2;
        g_win.p1_m1  = g_bot_q[1];
        g_win.p1_p1  = in_g;
        rb_win.m1_m1 = rb_top_q[1];
        rb_win.m1_p1 = rb_rd2;
        rb_win.p1_m1 = rb_bot_q[1];
        rb_win.p1_p1 = in_rb;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        if (accept) begin
            out_valid_d = win;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q      <= '0;
            y_q      <= '0;
            g_top_q  <= '0;
            g_bot_q  <= '0;
            rb_top_q <= '0;
            rb_bot_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            if (accept) begin
                g_top_q  <= {g_top_q[0], g_rd2};
                g_bot_q  <= {g_bot_q[0], in_g};
                rb_top_q <= {rb_top_q[0], rb_rd2};
                rb_bot_q <= {rb_bot_q[0], in_rb};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            g_q          <= '0;
            rb_q         <= '0;
            ctr_x_q      <= '0;
            ctr_y_q      <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            frame_done_q <= accept & last_col & last_row;
            if (accept && win) begin
                g_q     <= g_win;
                rb_q    <= rb_win;
                ctr_x_q <= cur_x - X_W'(1);
                ctr_y_q <= cur_y - Y_W'(1);
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign ctr_x      = ctr_x_q;
    assign ctr_y      = ctr_y_q;
    assign G_m1_m1    = g_q.m1_m1;
    assign G_m1_p1    = g_q.m1_p1;
    assign G_p1_m1    = g_q.p1_m1;
    assign G_p1_p1    = g_q.p1_p1;
    assign RB_m1_m1   = rb_q.m1_m1;
    assign RB_m1_p1   = rb_q.m1_p1;
    assign RB_p1_m1   = rb_q.p1_m1;
    assign RB_p1_p1   = rb_q.p1_p1;

endmodule

// File: tb/tb_diag_window_gen.sv
// Bench for diag_window_gen on an 8x6 image with in_g = 16*y+x, in_rb = 1000+16*y+x.
// A reference model keeps the received image as a 2-D array and queues the expected windows.
module tb_diag_window_gen;
    import cfa_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned H  = 6;
    localparam int unsigned XW = clog2(W);
    localparam int unsigned YW = clog2(H);

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_ready, in_sof, out_valid, out_ready, frame_done;
    logic [PIX_W-1:0] in_g, in_rb;
    logic [PIX_W-1:0] G_m1_m1, G_m1_p1, G_p1_m1, G_p1_p1;
    logic [PIX_W-1:0] RB_m1_m1, RB_m1_p1, RB_p1_m1, RB_p1_p1;
    logic [XW-1:0] ctr_x;
    logic [YW-1:0] ctr_y;

    always #5 clk = ~clk;

    diag_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sof     (in_sof),
        .in_g       (in_g),
        .in_rb      (in_rb),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .G_m1_m1    (G_m1_m1),
        .G_m1_p1    (G_m1_p1),
        .G_p1_m1    (G_p1_m1),
        .G_p1_p1    (G_p1_p1),
        .RB_m1_m1   (RB_m1_m1),
        .RB_m1_p1   (RB_m1_p1),
        .RB_p1_m1   (RB_p1_m1),
        .RB_p1_p1   (RB_p1_p1),
        .ctr_x      (ctr_x),
        .ctr_y      (ctr_y),
        .frame_done (frame_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int cx, cy;
        int g0, g1, g2, g3;
        int r0, r1, r2, r3;
    } win_t;

    win_t q[$];
    int   img_g[H][W];
    int   img_rb[H][W];
    int   mx, my, acc_since_sof, acc_at_first;
    bit   fd_pend, first_push_pending, first_pop_pending;
    int   win_cnt = 0;
    int   fd_cnt  = 0;
    int   f_cx, f_cy, l_cx, l_cy;
    int   f_g[4], f_r[4], l_g[4];

    bit   stall_arm = 0, stall_seen = 0, rand_ready = 0;
    int   stall_left = 0;

    // Model + compare: sampled 1 time unit before each rising edge.
    initial begin
        win_t w;
        bit   exp_valid;
        forever begin
            @(negedge clk);
            #4;
            if (!rst) begin
                q.delete();
                mx = 0; my = 0; fd_pend = 0; acc_since_sof = 0;
                first_push_pending = 1; first_pop_pending = 1;
                continue;
            end
            exp_valid = (q.size() > 0);
            check("in_ready", in_ready, out_ready | !exp_valid);
            check("out_valid", out_valid, exp_valid);
            check("frame_done", frame_done, fd_pend);
            if (frame_done) fd_cnt++;
            if (exp_valid) begin
                w = q[0];
                check("ctr_x", ctr_x, w.cx);
                check("ctr_y", ctr_y, w.cy);
                check("G_m1_m1", G_m1_m1, w.g0);
                check("G_m1_p1", G_m1_p1, w.g1);
                check("G_p1_m1", G_p1_m1, w.g2);
                check("G_p1_p1", G_p1_p1, w.g3);
                check("RB_m1_m1", RB_m1_m1, w.r0);
                check("RB_m1_p1", RB_m1_p1, w.r1);
                check("RB_p1_m1", RB_p1_m1, w.r2);
                check("RB_p1_p1", RB_p1_p1, w.r3);
                if (out_ready) begin
                    void'(q.pop_front());
                    win_cnt++;
                    if (first_pop_pending) begin
                        first_pop_pending = 0;
                        f_cx = ctr_x; f_cy = ctr_y;
                        f_g[0] = G_m1_m1;  f_g[1] = G_m1_p1;  f_g[2] = G_p1_m1;  f_g[3] = G_p1_p1;
                        f_r[0] = RB_m1_m1; f_r[1] = RB_m1_p1; f_r[2] = RB_p1_m1; f_r[3] = RB_p1_p1;
                    end
                    l_cx = ctr_x; l_cy = ctr_y;
                    l_g[0] = G_m1_m1; l_g[1] = G_m1_p1; l_g[2] = G_p1_m1; l_g[3] = G_p1_p1;
                end
            end
            fd_pend = 0;
            if (in_valid && (out_ready || !exp_valid)) begin
                if (in_sof) begin
                    mx = 0; my = 0; acc_since_sof = 0;
                    first_push_pending = 1; first_pop_pending = 1;
                end
                acc_since_sof++;
                img_g[my][mx]  = int'(in_g);
                img_rb[my][mx] = int'(in_rb);
                if (mx >= 2 && my >= 2) begin
                    w.cx = mx - 1; w.cy = my - 1;
                    w.g0 = img_g[my-2][mx-2];  w.g1 = img_g[my-2][mx];
                    w.g2 = img_g[my][mx-2];    w.g3 = img_g[my][mx];
                    w.r0 = img_rb[my-2][mx-2]; w.r1 = img_rb[my-2][mx];
                    w.r2 = img_rb[my][mx-2];   w.r3 = img_rb[my][mx];
                    q.push_back(w);
                    if (first_push_pending) begin
                        first_push_pending = 0;
                        acc_at_first = acc_since_sof;
                    end
                end
                if (mx == W - 1 && my == H - 1) fd_pend = 1;
                if (mx == W - 1) begin
                    mx = 0;
                    my = (my == H - 1) ? 0 : my + 1;
                end else begin
                    mx++;
                end
            end
        end
    end

    // Downstream ready: fixed 1, random, or a 5-cycle stall on the (3,2) window.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            #1;
            if (stall_arm && out_valid && ctr_x == 3 && ctr_y == 2) begin
                stall_left = 5; stall_arm = 0; stall_seen = 1;
            end
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
                #1;
                check("stall_in_ready", in_ready, 0);
                check("stall_G_m1_m1", G_m1_m1, 18);
            end else if (rand_ready) begin
                out_ready = ($urandom_range(0, 99) >= 25);
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    // Called at posedge+1; returns at posedge+1 after the pixel was accepted.
    task automatic send_pix(input int idx, input bit sof, input int gap_pct);
        int x, y, waited;
        bit r;
        x = idx % W;
        y = idx / W;
        while ($urandom_range(0, 99) < gap_pct) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_sof   = sof;
        in_g     = PIX_W'(16 * y + x);
        in_rb    = PIX_W'(1000 + 16 * y + x);
        waited   = 0;
        do begin
            @(negedge clk);
            #4;
            r = in_ready;
            @(posedge clk);
            #1;
            waited++;
        end while (!r && waited < 200);
        if (!r) check("accept_timeout", 0, 1);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_frame(input int n, input bit sof_first, input int gap_pct);
        for (int i = 0; i < n; i++) send_pix(i, sof_first && (i == 0), gap_pct);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() > 0 || out_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n == 200) check("drain_timeout", 0, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_first_last();
        check("pix_to_first_win", acc_at_first, 19);
        check("first_ctr_x", f_cx, 1);
        check("first_ctr_y", f_cy, 1);
        check("first_G_m1_m1", f_g[0], 0);
        check("first_G_m1_p1", f_g[1], 2);
        check("first_G_p1_m1", f_g[2], 32);
        check("first_G_p1_p1", f_g[3], 34);
        check("first_RB_m1_m1", f_r[0], 1000);
        check("first_RB_m1_p1", f_r[1], 1002);
        check("first_RB_p1_m1", f_r[2], 1032);
        check("first_RB_p1_p1", f_r[3], 1034);
        check("last_ctr_x", l_cx, 6);
        check("last_ctr_y", l_cy, 4);
        check("last_G_m1_m1", l_g[0], 53);
        check("last_G_m1_p1", l_g[1], 55);
        check("last_G_p1_m1", l_g[2], 85);
        check("last_G_p1_p1", l_g[3], 87);
    endtask

    initial begin
        int w0, f0;
        rst = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_g = '0; in_rb = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_ctr", {ctr_x, ctr_y}, 0);
        check("rst_data", G_m1_m1 | G_m1_p1 | G_p1_m1 | G_p1_p1 |
                          RB_m1_m1 | RB_m1_p1 | RB_p1_m1 | RB_p1_p1, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Continuous frame.
        w0 = win_cnt; f0 = fd_cnt;
        send_frame(W * H, 1, 0);
        drain();
        check_first_last();
        check("s1_windows", win_cnt - w0, 24);
        check("s1_frame_done", fd_cnt - f0, 1);

        // Downstream stall at centre (3,2).
        stall_seen = 0; stall_arm = 1;
        w0 = win_cnt;
        send_frame(W * H, 1, 0);
        drain();
        stall_arm = 0;
        check("s2_stall_seen", stall_seen, 1);
        check("s2_windows", win_cnt - w0, 24);

        // Random input gaps and random downstream back-pressure.
        rand_ready = 1;
        w0 = win_cnt;
        send_frame(W * H, 1, 30);
        rand_ready = 0;
        drain();
        check_first_last();
        check("s3_windows", win_cnt - w0, 24);

        // Two back-to-back frames.
        w0 = win_cnt; f0 = fd_cnt;
        send_frame(W * H, 1, 0);
        send_frame(W * H, 1, 0);
        drain();
        check("s4_windows", win_cnt - w0, 48);
        check("s4_frame_done", fd_cnt - f0, 2);
        check("s4_first_ctr_x", f_cx, 1);
        check("s4_first_ctr_y", f_cy, 1);
        check("s4_first_G_m1_m1", f_g[0], 0);

        // sof at pixel index 20 abandons the frame in flight.
        w0 = win_cnt;
        send_frame(20, 1, 0);
        send_frame(W * H, 1, 0);
        drain();
        check_first_last();
        check("s5_windows", win_cnt - w0, 26);

        // Asynchronous reset mid-frame while a window is pending.
        send_frame(30, 1, 0);
        check("s6_pre_rst_valid", out_valid, 1);
        #1;
        rst = 1'b0;
        #1;
        check("s6_rst_out_valid", out_valid, 0);
        check("s6_rst_frame_done", frame_done, 0);
        check("s6_rst_ctr", {ctr_x, ctr_y}, 0);
        check("s6_rst_data", G_m1_m1 | G_m1_p1 | G_p1_m1 | G_p1_p1 |
                             RB_m1_m1 | RB_m1_p1 | RB_p1_m1 | RB_p1_p1, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        w0 = win_cnt; f0 = fd_cnt;
        send_frame(W * H, 0, 0);
        drain();
        check_first_last();
        check("s6_windows", win_cnt - w0, 24);
        check("s6_frame_done", fd_cnt - f0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
